// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared constants and state type for the round-robin mux select arbiter
package mux_sel_pkg;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;
    localparam int BEAT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-then-priority-encode: first set request searching upward from ptr+1
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  pick_idx,
    output logic              pick_any
);

    logic [SEL_W-1:0]  start;
    logic [NUM_IN-1:0] rot;
    logic [SEL_W-1:0]  off;

    always_comb begin
        start = ptr + 1'b1;
        rot   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            rot[i] = req[start + SEL_W'(i)];
        end
        // Scan downward so the lowest rotated position (nearest to ptr+1) wins.
        off = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        pick_idx = start + off;
        pick_any = |req;
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin arbiter driving a registered 4:1 mux select; optional RR_SEL_LOCK_EN adds burst lock
module rr_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              last,
    input  logic              ready,
`ifdef RR_SEL_LOCK_EN
    input  logic              lock,
`endif
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_IN-1:0] gnt,
    output logic              valid
);

    localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(MAX_BURST - 1);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_IN-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hs;
    logic              lock_hold;
    logic              limit_hit;
    logic [BEAT_W-1:0] beat_inc;

    rr_pick u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    assign sel   = sel_q;
    assign gnt   = gnt_q;
    assign valid = (state_q == GRANT) && req[sel_q];
    assign hs    = valid && ready;

`ifdef RR_SEL_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Saturating increment only matters while locked; otherwise the limit releases first.
    assign beat_inc  = (beat_q == {BEAT_W{1'b1}}) ? beat_q : beat_q + 1'b1;
    // >= rather than == so dropping lock after a long locked burst releases on that beat.
    assign limit_hit = (beat_q >= BURST_LAST) && !lock_hold;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    sel_d   = pick_idx;
                    gnt_d   = {{(NUM_IN-1){1'b0}}, 1'b1} << pick_idx;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (hs) begin
                    beat_d = beat_inc;
                end
                if (!req[sel_q] || (hs && (last || limit_hit))) begin
                    ptr_d   = sel_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= SEL_W'(NUM_IN - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - self-checking bench for rr_sel_arbiter (table, directed and randomized model checks)
module tb_rr_sel_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       last = 1'b0;
    logic       ready = 1'b0;
    logic       lock = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: granted index (-1 when none), last sel, last granted, beats done.
    int m_gidx, m_sel, m_ptr, m_beats;

    rr_sel_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .last  (last),
        .ready (ready),
`ifdef RR_SEL_LOCK_EN
        .lock  (lock),
`endif
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] exp_sel;
        logic [3:0] exp_gnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        last  = 1'b0;
        lock  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_gidx  = -1;
        m_sel   = 0;
        m_ptr   = 3;
        m_beats = 0;
    endtask

    function automatic int first_from(input int p, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rd, input logic l);
        if (m_gidx < 0) begin
            int pick;
            pick = first_from(m_ptr, r);
            if (pick >= 0) begin
                m_gidx  = pick;
                m_sel   = pick;
                m_beats = 0;
            end
        end else if (!r[m_gidx]) begin
            m_ptr  = m_gidx;
            m_gidx = -1;
        end else if (rd) begin
            m_beats++;
            if (l || m_beats == MAXB) begin
                m_ptr  = m_gidx;
                m_gidx = -1;
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        logic [3:0] exp_g;
        logic       exp_v;

        vecs[0] = '{4'b0001, 2'd0, 4'b0001};
        vecs[1] = '{4'b0010, 2'd1, 4'b0010};
        vecs[2] = '{4'b0110, 2'd1, 4'b0010};
        vecs[3] = '{4'b1100, 2'd2, 4'b0100};
        vecs[4] = '{4'b1000, 2'd3, 4'b1000};
        vecs[5] = '{4'b1111, 2'd0, 4'b0001};
        vecs[6] = '{4'b1010, 2'd1, 4'b0010};

        // Reset values
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);

        // First grant after reset: lowest set request wins (ptr starts at 3)
        for (int i = 0; i < 7; i++) begin
            do_reset();
            req = vecs[i].req;
            #1;
            chk("tbl_idle_gnt", 32'(gnt), 32'h0);
            tick();
            chk("tbl_sel", 32'(sel), 32'(vecs[i].exp_sel));
            chk("tbl_gnt", 32'(gnt), 32'(vecs[i].exp_gnt));
            chk("tbl_valid", 32'(valid), 32'h1);
        end

        // Single beat with last, then ptr=0 moves next priority to 1
        do_reset();
        req = 4'b0001; ready = 1'b1; last = 1'b1;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'(sel), 32'h0);
        tick();
        chk("t1_release", 32'(gnt), 32'h0);
        chk("t1_bubble_valid", 32'(valid), 32'h0);
        req = 4'b1111; last = 1'b0;
        tick();
        chk("t1_ptr_next", 32'(sel), 32'h1);

        // Persistent requests rotate with MAX_BURST beats each and one bubble
        do_reset();
        req = 4'b1111; ready = 1'b1; last = 1'b0;
        tick();
        for (int g = 0; g < 5; g++) begin
            chk("t2_sel", 32'(sel), 32'(g % 4));
            chk("t2_gnt", 32'(gnt), 32'(1 << (g % 4)));
            for (int b = 0; b < MAXB; b++) begin
                chk("t2_beat_valid", 32'(valid), 32'h1);
                tick();
            end
            chk("t2_bubble_gnt", 32'(gnt), 32'h0);
            chk("t2_bubble_sel_hold", 32'(sel), 32'(g % 4));
            tick();
        end

        // Stall on requester 2, then last releases and 3 is next
        do_reset();
        req = 4'b0100; ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_stall_sel", 32'(sel), 32'h2);
            chk("t3_stall_gnt", 32'(gnt), 32'h4);
        end
        req = 4'b1100; ready = 1'b1; last = 1'b0;
        for (int b = 0; b < MAXB - 1; b++) tick();
        chk("t3_no_count_in_stall", 32'(gnt), 32'h4);
        last = 1'b1;
        tick();
        chk("t3_release", 32'(gnt), 32'h0);
        last = 1'b0;
        tick();
        chk("t3_next_sel", 32'(sel), 32'h3);

        // Granted requester 1 withdraws with 0 and 3 pending
        do_reset();
        req = 4'b0010; ready = 1'b0;
        tick();
        chk("t4_sel", 32'(sel), 32'h1);
        ready = 1'b1;
        tick();
        req = 4'b1001;
        #1;
        chk("t4_valid_drop", 32'(valid), 32'h0);
        tick();
        chk("t4_release", 32'(gnt), 32'h0);
        tick();
        chk("t4_next_sel", 32'(sel), 32'h3);
        chk("t4_next_gnt", 32'(gnt), 32'h8);

        // Asynchronous reset mid-burst
        do_reset();
        req = 4'b1000; ready = 1'b1;
        tick();
        chk("t5_sel", 32'(sel), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_gnt", 32'(gnt), 32'h0);
        chk("t5_async_valid", 32'(valid), 32'h0);
        #2;
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("t5_after_sel", 32'(sel), 32'h0);

`ifdef RR_SEL_LOCK_EN
        // Lock holds the grant past MAX_BURST; dropping it releases on that handshake
        do_reset();
        req = 4'b0001; ready = 1'b1; lock = 1'b1;
        tick();
        for (int b = 0; b < 10; b++) begin
            chk("t6_lock_valid", 32'(valid), 32'h1);
            chk("t6_lock_gnt", 32'(gnt), 32'h1);
            tick();
        end
        lock = 1'b0;
        tick();
        chk("t6_unlock_release", 32'(gnt), 32'h0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(9) == 0) req[i] = ~req[i];
            end
            ready = ($urandom_range(3) != 0);
            last  = ($urandom_range(4) == 0);
            #1;
            exp_g = (m_gidx < 0) ? 4'b0 : 4'(1 << m_gidx);
            exp_v = (m_gidx >= 0) && req[m_gidx];
            chk("rnd_gnt", 32'(gnt), 32'(exp_g));
            chk("rnd_sel", 32'(sel), 32'(m_sel));
            chk("rnd_valid", 32'(valid), 32'(exp_v));
            @(posedge clk);
            model_step(req, ready, last);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
